// File: rtl/exe_ctrl_fifo_pkg.sv
// Shared core definitions for the execution-lane control FIFO:
// the ctrlPkt writeback packet and the default buffer depth.
package exe_ctrl_fifo_pkg;

    localparam int unsigned CTRL_FIFO_DEPTH = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [5:0]  robIdx;
        logic        brMispred;
        logic        excValid;
        logic [3:0]  excCode;
    } ctrlPkt;

endpackage

// File: rtl/exe_ctrl_fifo.sv
// Per-lane circular FIFO buffering ctrlPkt entries between writeback and the active list.
// Optional same-cycle empty-FIFO bypass: define CTRL_FIFO_BYPASS_EN.
module exe_ctrl_fifo
    import exe_ctrl_fifo_pkg::*;
#(
    parameter int unsigned DEPTH = CTRL_FIFO_DEPTH,
    parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush_i,
    input  logic             enqValid_i,
    input  ctrlPkt           ctrlPacket_i,
    output logic             full_o,
    input  logic             deqReady_i,
    output logic             deqValid_o,
    output ctrlPkt           ctrlPacket_o,
    output logic [CNT_W-1:0] count_o,
    output logic             overflow_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    ctrlPkt             mem_q [DEPTH];
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               overflow_q, overflow_d;
    logic               empty, full, bypass, enq_fire, deq_fire, wr_en;

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(DEPTH));

`ifdef CTRL_FIFO_BYPASS_EN
    // A bypassed packet is consumed directly and never touches storage or pointers.
    assign bypass       = enqValid_i & deqReady_i & empty & ~flush_i;
    assign deqValid_o   = ~flush_i & (~empty | bypass);
    assign ctrlPacket_o = bypass ? ctrlPacket_i : mem_q[head_q];
`else
    assign bypass       = 1'b0;
    assign deqValid_o   = ~empty;
    assign ctrlPacket_o = mem_q[head_q];
`endif

    assign deq_fire   = deqValid_o & deqReady_i;
    assign enq_fire   = enqValid_i & (~full | deq_fire);
    assign full_o     = full;
    assign count_o    = count_q;
    assign overflow_o = overflow_q;

    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        wr_en      = 1'b0;
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (enq_fire && !bypass) begin
                wr_en  = 1'b1;
                tail_d = tail_q + PTR_W'(1);
            end
            if (deq_fire && !bypass) begin
                head_d = head_q + PTR_W'(1);
            end
            if (enq_fire && !deq_fire) begin
                count_d = count_q + CNT_W'(1);
            end else if (!enq_fire && deq_fire) begin
                count_d = count_q - CNT_W'(1);
            end
            if (enqValid_i && full && !deq_fire) begin
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[tail_q] <= ctrlPacket_i;
        end
    end

endmodule

// File: tb/tb_exe_ctrl_fifo.sv
// Randomized and directed bench for exe_ctrl_fifo against a queue-based reference model.
module tb_exe_ctrl_fifo;
    import exe_ctrl_fifo_pkg::*;

    localparam int unsigned DEPTH = CTRL_FIFO_DEPTH;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             flush_i, enqValid_i, deqReady_i;
    ctrlPkt           ctrlPacket_i;
    logic             full_o, deqValid_o, overflow_o;
    ctrlPkt           ctrlPacket_o;
    logic [CNT_W-1:0] count_o;

    int unsigned checks = 0;
    int unsigned errors = 0;
    ctrlPkt      model_q[$];
    logic        ovf_m = 1'b0;

    exe_ctrl_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .flush_i      (flush_i),
        .enqValid_i   (enqValid_i),
        .ctrlPacket_i (ctrlPacket_i),
        .full_o       (full_o),
        .deqReady_i   (deqReady_i),
        .deqValid_o   (deqValid_o),
        .ctrlPacket_o (ctrlPacket_o),
        .count_o      (count_o),
        .overflow_o   (overflow_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic ctrlPkt mk_pkt(input logic [31:0] pc);
        ctrlPkt p;
        p = ctrlPkt'({$urandom, $urandom});
        p.pc = pc;
        return p;
    endfunction

    // One clock: drive at negedge, compare against the model, advance the model.
    task automatic cyc(input logic enq, input logic dr, input logic fl, input ctrlPkt pkt);
        logic   empty_m, full_m, byp, vld, dq, eq;
        ctrlPkt tmp;
        @(negedge clk);
        enqValid_i   = enq;
        deqReady_i   = dr;
        flush_i      = fl;
        ctrlPacket_i = pkt;
        #1;
        empty_m = (model_q.size() == 0);
        full_m  = (model_q.size() == DEPTH);
        byp     = 1'b0;
`ifdef CTRL_FIFO_BYPASS_EN
        byp = enq & dr & empty_m & !fl;
        vld = !fl & (!empty_m | byp);
`else
        vld = !empty_m;
`endif
        check("count", 64'(count_o), 64'(model_q.size()));
        check("full", 64'(full_o), 64'(full_m));
        check("valid", 64'(deqValid_o), 64'(vld));
        check("overflow", 64'(overflow_o), 64'(ovf_m));
        if (vld) check("pkt", 64'(ctrlPacket_o), 64'(byp ? pkt : model_q[0]));
        dq = vld & dr;
        eq = enq & (!full_m | dq);
        if (fl) begin
            model_q.delete();
        end else begin
            if (enq && full_m && !dq) ovf_m = 1'b1;
            if (!byp) begin
                if (dq) tmp = model_q.pop_front();
                if (eq) model_q.push_back(pkt);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        enqValid_i = 1'b0;
        deqReady_i = 1'b0;
        flush_i    = 1'b0;
    endtask

    initial begin
        reset        = 1'b0;
        ctrlPacket_i = '0;
        idle_inputs();
        repeat (3) @(posedge clk);
        #1;
        check("rst_count", 64'(count_o), 64'd0);
        check("rst_valid", 64'(deqValid_o), 64'd0);
        check("rst_full", 64'(full_o), 64'd0);
        check("rst_ovf", 64'(overflow_o), 64'd0);
        @(negedge clk);
        reset = 1'b1;

        // Fill in order, then drain in order.
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b0, mk_pkt(32'h100 + 32'(4 * i)));
        check("fill_count", 64'(count_o), 64'(DEPTH));
        check("fill_full", 64'(full_o), 64'(DEPTH == 4));
        for (int i = 0; i < 4; i++) begin
            check("drain_pc", 64'(ctrlPacket_o.pc), 64'(32'h100 + 32'(4 * i)));
            cyc(1'b0, 1'b1, 1'b0, mk_pkt(32'hdead));
        end
        check("drain_count", 64'(count_o), 64'd0);

        // Full with simultaneous enq/deq across pointer wrap.
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, 1'b0, 1'b0, mk_pkt(32'h300 + 32'(4 * i)));
        for (int i = 0; i < 8; i++) begin
            check("wrap_pc", 64'(ctrlPacket_o.pc), 64'(32'h300 + 32'(4 * i)));
            cyc(1'b1, 1'b1, 1'b0, mk_pkt(32'h300 + 32'(4 * (i + DEPTH))));
            check("wrap_count", 64'(count_o), 64'(DEPTH));
            check("wrap_ovf", 64'(overflow_o), 64'd0);
        end

        // Enqueue while full with no dequeue: dropped, sticky overflow.
        cyc(1'b1, 1'b0, 1'b0, mk_pkt(32'hbad0));
        check("ovf_set", 64'(overflow_o), 64'd1);
        check("ovf_count", 64'(count_o), 64'(DEPTH));
        for (int i = 0; i < DEPTH; i++) begin
            check("ovf_nodrop", 64'(ctrlPacket_o.pc == 32'hbad0), 64'd0);
            cyc(1'b0, 1'b1, 1'b0, mk_pkt(32'h0));
        end
        check("ovf_sticky", 64'(overflow_o), 64'd1);

        // Async reset mid-operation with two entries.
        cyc(1'b1, 1'b0, 1'b0, mk_pkt(32'h400));
        cyc(1'b1, 1'b0, 1'b0, mk_pkt(32'h404));
        idle_inputs();
        check("pre_rst_count", 64'(count_o), 64'd2);
        #2 reset = 1'b0;
        #1;
        check("async_count", 64'(count_o), 64'd0);
        check("async_valid", 64'(deqValid_o), 64'd0);
        check("async_full", 64'(full_o), 64'd0);
        check("async_ovf", 64'(overflow_o), 64'd0);
        model_q.delete();
        ovf_m = 1'b0;
        @(negedge clk);
        reset = 1'b1;

        // Flush beats a same-cycle enqueue and dequeue.
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, mk_pkt(32'h500 + 32'(4 * i)));
        check("pre_flush_count", 64'(count_o), 64'd3);
        cyc(1'b1, 1'b1, 1'b1, mk_pkt(32'h5ff));
        idle_inputs();
        check("flush_count", 64'(count_o), 64'd0);
        check("flush_valid", 64'(deqValid_o), 64'd0);

        // Empty-FIFO enqueue with ready: bypass latency depends on the build.
        @(negedge clk);
        enqValid_i   = 1'b1;
        deqReady_i   = 1'b1;
        ctrlPacket_i = mk_pkt(32'h200);
        #1;
`ifdef CTRL_FIFO_BYPASS_EN
        check("byp_same_valid", 64'(deqValid_o), 64'd1);
        check("byp_same_pc", 64'(ctrlPacket_o.pc), 64'h200);
        @(posedge clk);
        #1;
        idle_inputs();
        #1;
        check("byp_next_count", 64'(count_o), 64'd0);
`else
        check("nobyp_same_valid", 64'(deqValid_o), 64'd0);
        @(posedge clk);
        #1;
        idle_inputs();
        #1;
        check("nobyp_next_valid", 64'(deqValid_o), 64'd1);
        check("nobyp_next_pc", 64'(ctrlPacket_o.pc), 64'h200);
        model_q.push_back(ctrlPacket_i);
`endif

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            cyc(1'($urandom_range(0, 99) < 60), 1'($urandom_range(0, 99) < 50),
                1'($urandom_range(0, 99) < 3), mk_pkt($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
